audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Playback-side serial audio transmitter for the WM8731 codec, running in master mode. It generates the bit clock (BCK) and the left/right clock (LRCK), and shifts 16-bit left/right samples out on the DAC data line in left-justified format. Stereo samples arrive through a one-deep valid/ready holding register, which the SRAM playback reader fills. It is the transmit counterpart of the recording path, which deserializes ADC data and writes it to SRAM.

## Interface
- CLK_DIV, default 6: iCLK cycles per BCK half-period. At 18.432 MHz this gives a 1.536 MHz BCK.
- DATA_WIDTH, default 16: bits per channel. A frame is 2*DATA_WIDTH BCK periods.
- iCLK  in  1  audio control clock (18.432 MHz); all logic is on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iEN  in  1  transmit enable.
- iL  in  DATA_WIDTH  left sample, two's complement.
- iR  in  DATA_WIDTH  right sample, two's complement.
- iVALID  in  1  {iL,iR} is valid this cycle.
- oREADY  out  1  holding register empty; a sample is accepted when iVALID && oREADY.
- oAUD_BCK  out  1  bit clock to the codec.
- oAUD_LRCK  out  1  frame clock; 1 = left channel, 0 = right channel.
- oAUD_DATA  out  1  serial DAC data, MSB first.
- oFRAME_START  out  1  one-cycle pulse when a frame is loaded; the SRAM reader uses it to advance its address.
- oUNDERRUN  out  1  one-cycle pulse when a frame is loaded from an empty holding register.
- oUNDERRUN_CNT  out  8  saturating underrun count.

## Operation
- All outputs are registered.
- Reset values: oAUD_BCK=0, oAUD_LRCK=0, oAUD_DATA=0, oREADY=1, oFRAME_START=0, oUNDERRUN=0, oUNDERRUN_CNT=0. The state machine resets to IDLE and the holding register to empty.
- The state machine has three states: IDLE, LEFT and RIGHT.
  - IDLE: BCK, LRCK and DATA are held at 0, and all counters are at 0.
  - IDLE -> LEFT on the first cycle that iEN=1. That cycle is a load cycle.
  - LEFT -> RIGHT after DATA_WIDTH BCK periods. On that falling edge LRCK goes 0 and DATA presents the right-channel MSB.
  - RIGHT -> LEFT after DATA_WIDTH BCK periods, if iEN=1. This is a load cycle.
  - RIGHT -> IDLE at the end of the frame if iEN=0.
- Clear iEN mid-frame: the current frame completes (all 2*DATA_WIDTH bits), then the block goes to IDLE. The holding register is kept.
- Load cycle:
  - If the holding register is full: move {L,R} into the shift register, empty the holding register, and set oREADY=1 on the next edge.
  - If the holding register is empty: load zeros (mute), pulse oUNDERRUN, and increment oUNDERRUN_CNT, saturating at 255.
  - In both cases pulse oFRAME_START.
- Handshake: acceptance (which needs an empty register) and load transfer (which needs a full register) are mutually exclusive, so no arbitration is required. With iVALID=1 and oREADY=0, the input is ignored and the holding register is not overwritten.
- Serialization:
  - DATA changes only on BCK falling edges; the codec samples it on BCK rising edges.
  - Left-justified: the MSB appears on the same falling edge as the LRCK transition, with no one-BCK delay.
  - The shift register is 2*DATA_WIDTH bits, left then right, shifting left.

## Timing
- A BCK half-period is CLK_DIV iCLK cycles, so the BCK period is 12 cycles and a frame is 2*DATA_WIDTH*2*CLK_DIV = 384 cycles (48 kHz).
- Load cycle at edge t: at t+1, LRCK=1, BCK=0, DATA=L[DATA_WIDTH-1], oFRAME_START=1. oFRAME_START is low again at t+2.
- BCK rises at t+1+CLK_DIV. Data bit k (0 = left MSB) is stable from edge t+1+2*CLK_DIV*k and is sampled at edge t+1+2*CLK_DIV*k+CLK_DIV.
- The LRCK falling edge and the right MSB appear at t+1+DATA_WIDTH*2*CLK_DIV. The next load cycle ends at t+384.
- Accept-to-air latency:
  - Best case (accepted in the cycle just before a load cycle): 2 cycles to the MSB on DATA.
  - Worst case: one frame plus 2 cycles.
- Counters:
  - div_cnt runs 0..CLK_DIV-1 and toggles BCK at terminal count.
  - bit_cnt runs 0..2*DATA_WIDTH-1, advancing on BCK falling edges and wrapping to 0 on a load.
- Asserting iRST mid-frame forces all outputs and state to their reset values immediately (asynchronously). After release, the block restarts from IDLE; no partial frame resumes.

## Structure
- A shared audio_pkg/include holds: the AUD_DATA_WIDTH and AUD_CLK_DIV defaults, the state encoding (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2), and the frame length constant.
- The BCK/LRCK divider is a natural sub-module, audio_bclk_gen. It outputs BCK, a falling-edge strobe, and a frame-end strobe, and it is reusable by the ADC receiver.

## Test plan
- Reset: hold iRST for 5 cycles -> all outputs at their reset values and oREADY=1. With iEN=0 after release, no BCK toggles for 1000 cycles.
- Single sample: accept L=16'hA5F0, R=16'h0F0F, then assert iEN.
  - Bits sampled on BCK rising edges are 1010_0101_1111_0000 with LRCK=1, then 0000_1111_0000_1111 with LRCK=0.
  - oFRAME_START pulses once, and oREADY returns to 1 two cycles after the load.
- Streaming: the reader writes a ramp 0,1,2,... on every oFRAME_START for 10 frames -> each frame carries the next value, there is no underrun, and the frame period is 384 cycles.
- Underrun: iEN=1 with no writes for 3 frames -> DATA stays 0, oUNDERRUN pulses 3 times, and oUNDERRUN_CNT=3. Forcing 300 underruns leaves oUNDERRUN_CNT=255.
- Disable mid-frame: drop iEN at bit 5 of the left channel -> all 32 bits complete, then IDLE with BCK=LRCK=0. A pending holding sample remains and oREADY stays 0.
- Reset mid-frame: pulse iRST at bit 20 -> outputs are 0 in the same cycle. Re-enabling gives a fresh frame starting at the left MSB.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the codec serial audio path.
// Latency: none (definitions only).
// Backpressure: not applicable.
package audio_pkg;

  localparam int AUD_DATA_WIDTH = 16;
  localparam int AUD_CLK_DIV    = 6;

  // Control-clock cycles in one stereo frame: 2 channels x bits x BCK period.
  function automatic int aud_frame_cycles(input int data_width, input int clk_div);
    return 2 * data_width * 2 * clk_div;
  endfunction

  localparam int AUD_FRAME_CYCLES = aud_frame_cycles(AUD_DATA_WIDTH, AUD_CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } aud_state_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: BCK, falling-edge strobe, frame-end strobe, bit counter.
// Latency: BCK first rises CLK_DIV cycles after i_run goes high; strobes are combinational.
// Backpressure: none; counters free-run while i_run=1 and sit at zero otherwise.
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = AUD_CLK_DIV,
  parameter int DATA_WIDTH = AUD_DATA_WIDTH,
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
  localparam int BW = $clog2(2 * DATA_WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  output logic          o_bck,
  output logic          o_fall,
  output logic          o_frame_end,
  output logic [BW-1:0] o_bit_cnt
);

  logic [CW-1:0] r_div_cnt;
  logic          r_bck;
  logic [BW-1:0] r_bit_cnt;
  logic          w_tc;

  assign w_tc        = (r_div_cnt == CW'(CLK_DIV - 1));
  // The edge that drops BCK is the one where DATA is allowed to change.
  assign o_fall      = i_run && w_tc && r_bck;
  assign o_frame_end = o_fall && (r_bit_cnt == BW'(2 * DATA_WIDTH - 1));
  assign o_bck       = r_bck;
  assign o_bit_cnt   = r_bit_cnt;

  // Divide the control clock into BCK and count bits on BCK falling edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      if (w_tc) begin
        r_div_cnt <= '0;
        r_bck     <= ~r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (o_fall) begin
        r_bit_cnt <= o_frame_end ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// Left-justified master-mode DAC serializer with a one-deep sample holding register.
// Latency: sample accepted just before a load reaches DATA one edge after the load decision.
// Backpressure: oREADY low while the holding register is full; an empty register at load mutes the frame.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = AUD_CLK_DIV,
  parameter int DATA_WIDTH = AUD_DATA_WIDTH
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iEN,
  input  logic [DATA_WIDTH-1:0] iL,
  input  logic [DATA_WIDTH-1:0] iR,
  input  logic                  iVALID,
  output logic                  oREADY,
  output logic                  oAUD_BCK,
  output logic                  oAUD_LRCK,
  output logic                  oAUD_DATA,
  output logic                  oFRAME_START,
  output logic                  oUNDERRUN,
  output logic [7:0]            oUNDERRUN_CNT
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(SW);

  aud_state_t      r_state;
  logic [SW-1:0]   r_hold;
  logic [SW-1:0]   r_shift;
  logic            r_full;
  logic            r_ready;
  logic            r_lrck;
  logic            r_data;
  logic            r_frame_start;
  logic            r_underrun;
  logic [7:0]      r_urun_cnt;

  logic            w_bck;
  logic            w_fall;
  logic            w_frame_end;
  logic [BW-1:0]   w_bit_cnt;
  logic            w_run;
  logic            w_load;
  logic            w_accept;
  logic [SW-1:0]   w_payload;

  assign w_run     = (r_state != ST_IDLE);
  // A load happens on leaving IDLE or at the end of a frame, only while enabled.
  assign w_load    = iEN && ((r_state == ST_IDLE) || ((r_state == ST_RIGHT) && w_frame_end));
  assign w_accept  = iVALID && r_ready;
  assign w_payload = r_full ? r_hold : '0;

  audio_bclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bclk (
    .i_clk       (iCLK),
    .i_rst       (iRST),
    .i_run       (w_run),
    .o_bck       (w_bck),
    .o_fall      (w_fall),
    .o_frame_end (w_frame_end),
    .o_bit_cnt   (w_bit_cnt)
  );

  // Holding register; READY re-opens one edge after a load empties it, so an
  // accept can never coincide with a transfer out of a full register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_ready <= ~r_full && !w_accept;
      if (w_accept) begin
        r_full <= 1'b1;
        r_hold <= {iL, iR};
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

  // Frame-start and underrun pulses plus the saturating underrun counter.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_urun_cnt    <= '0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_full;
      if (w_load && !r_full && (r_urun_cnt != 8'hFF)) begin
        r_urun_cnt <= r_urun_cnt + 8'd1;
      end
    end
  end

  // Channel state machine driving LRCK and the MSB-first shift register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_lrck  <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_LEFT;
            r_shift <= w_payload;
            r_data  <= w_payload[SW-1];
            r_lrck  <= 1'b1;
          end else begin
            r_shift <= '0;
            r_data  <= 1'b0;
            r_lrck  <= 1'b0;
          end
        end
        ST_LEFT: begin
          if (w_fall) begin
            r_shift <= {r_shift[SW-2:0], 1'b0};
            r_data  <= r_shift[SW-2];
            if (w_bit_cnt == BW'(DATA_WIDTH - 1)) begin
              r_state <= ST_RIGHT;
              r_lrck  <= 1'b0;
            end
          end
        end
        ST_RIGHT: begin
          if (w_frame_end) begin
            if (w_load) begin
              r_state <= ST_LEFT;
              r_shift <= w_payload;
              r_data  <= w_payload[SW-1];
              r_lrck  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_shift <= '0;
              r_data  <= 1'b0;
              r_lrck  <= 1'b0;
            end
          end else if (w_fall) begin
            r_shift <= {r_shift[SW-2:0], 1'b0};
            r_data  <= r_shift[SW-2];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_shift <= '0;
          r_data  <= 1'b0;
          r_lrck  <= 1'b0;
        end
      endcase
    end
  end

  assign oREADY        = r_ready;
  assign oAUD_BCK      = w_bck;
  assign oAUD_LRCK     = r_lrck;
  assign oAUD_DATA     = r_data;
  assign oFRAME_START  = r_frame_start;
  assign oUNDERRUN     = r_underrun;
  assign oUNDERRUN_CNT = r_urun_cnt;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: default instance plus a tiny-frame instance for counter saturation.
// Latency: checks load, first BCK rise and last bit timing against frame-start pulses.
// Backpressure: drives the holding-register handshake only when oREADY is seen high.
module tb_audio_dac_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] l_dat;
  logic [15:0] r_dat;
  logic        vld;
  logic        rdy;
  logic        bck;
  logic        lrck;
  logic        sdat;
  logic        fs;
  logic        urun;
  logic [7:0]  urun_cnt;

  logic        s_rst;
  logic        s_en;
  logic [1:0]  s_l;
  logic [1:0]  s_r;
  logic        s_vld;
  logic        s_rdy;
  logic        s_bck;
  logic        s_lrck;
  logic        s_dat;
  logic        s_fs;
  logic        s_urun;
  logic [7:0]  s_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fs_pulses = 0;
  int ur_pulses = 0;
  int t_fs  = 0;

  audio_dac_tx dut (
    .iCLK (clk), .iRST (rst), .iEN (en), .iL (l_dat), .iR (r_dat), .iVALID (vld),
    .oREADY (rdy), .oAUD_BCK (bck), .oAUD_LRCK (lrck), .oAUD_DATA (sdat),
    .oFRAME_START (fs), .oUNDERRUN (urun), .oUNDERRUN_CNT (urun_cnt)
  );

  audio_dac_tx #(.CLK_DIV(1), .DATA_WIDTH(2)) dut_s (
    .iCLK (clk), .iRST (s_rst), .iEN (s_en), .iL (s_l), .iR (s_r), .iVALID (s_vld),
    .oREADY (s_rdy), .oAUD_BCK (s_bck), .oAUD_LRCK (s_lrck), .oAUD_DATA (s_dat),
    .oFRAME_START (s_fs), .oUNDERRUN (s_urun), .oUNDERRUN_CNT (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fs)   fs_pulses <= fs_pulses + 1;
    if (urun) ur_pulses <= ur_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one sample once READY is seen, held for exactly one edge.
  task automatic push(input logic [15:0] lv, input logic [15:0] rv);
    int w;
    w = 0;
    while (!rdy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("push_rdy_timeout", 32'(rdy), 32'd1);
    l_dat = lv;
    r_dat = rv;
    vld   = 1'b1;
    @(negedge clk);
    vld   = 1'b0;
  endtask

  // Wait for the next frame-start pulse and timestamp it.
  task automatic wait_fs(input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!fs && w < 1000);
    chk(tag, 32'(fs), 32'd1);
    t_fs = cyc;
  endtask

  // Collect bits and LRCK seen at BCK rising edges; optionally drop iEN at a bit index.
  task automatic cap_frame(input int nbits, input int drop_at,
                           output logic [31:0] bits, output logic [31:0] lrs,
                           output int first_rise, output int last_rise);
    int   n;
    logic prev;
    n = 0;
    bits = '0;
    lrs  = '0;
    first_rise = -1;
    last_rise  = -1;
    prev = bck;
    for (int c = 0; c < 500 && n < nbits; c++) begin
      @(negedge clk);
      if (bck && !prev) begin
        bits = {bits[30:0], sdat};
        lrs  = {lrs[30:0], lrck};
        if (n == 0) first_rise = cyc - t_fs;
        last_rise = cyc - t_fs;
        n++;
        if (n == drop_at) en = 1'b0;
      end
      prev = bck;
    end
    chk("cap_timeout", 32'(n), 32'(nbits));
  endtask

  logic [31:0] bits;
  logic [31:0] lrs;
  int          fr;
  int          lr;
  int          hi;
  int          prev_fs;
  int          fs0;
  int          ur0;
  int          sn;
  int          w;

  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; l_dat = '0; r_dat = '0;
    s_rst = 1'b1; s_en = 1'b0; s_vld = 1'b0; s_l = '0; s_r = '0;

    // Reset values.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {27'd0, bck, lrck, sdat, fs, urun}, 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_cnt", 32'(urun_cnt), 32'd0);
    rst = 1'b0;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bck || lrck || sdat) hi++;
    end
    chk("idle_quiet", 32'(hi), 32'd0);

    // Single sample.
    fs0 = fs_pulses;
    push(16'hA5F0, 16'h0F0F);
    chk("rdy_low_full", 32'(rdy), 32'd0);
    en = 1'b1;
    wait_fs("fs_single");
    en = 1'b0;
    chk("load_outs", {28'd0, bck, lrck, sdat, rdy}, 32'b0110);
    @(negedge clk);
    chk("load_next", {30'd0, fs, rdy}, 32'b01);
    cap_frame(32, -1, bits, lrs, fr, lr);
    chk("single_bits", bits, 32'hA5F0_0F0F);
    chk("single_lrck", lrs, 32'hFFFF_0000);
    chk("first_rise", 32'(fr), 32'd6);
    chk("last_rise", 32'(lr), 32'd378);
    repeat (30) @(negedge clk);
    chk("single_fs_cnt", 32'(fs_pulses - fs0), 32'd1);
    chk("single_idle", {29'd0, bck, lrck, sdat}, 32'd0);
    chk("single_no_urun", 32'(urun_cnt), 32'd0);

    // Streaming ramp, one write per frame start.
    push(16'd0, ~16'd0);
    en = 1'b1;
    prev_fs = 0;
    for (int f = 0; f < 10; f++) begin
      wait_fs("fs_stream");
      if (f > 0) chk("stream_period", 32'(t_fs - prev_fs), 32'd384);
      prev_fs = t_fs;
      chk("stream_urun", 32'(urun), 32'd0);
      if (f < 9) push(16'(f + 1), ~16'(f + 1));
      cap_frame(32, -1, bits, lrs, fr, lr);
      chk("stream_bits", bits, {16'(f), ~16'(f)});
    end
    chk("stream_cnt", 32'(urun_cnt), 32'd0);

    // Underrun: three muted frames.
    ur0 = ur_pulses;
    for (int u = 0; u < 3; u++) begin
      wait_fs("fs_urun");
      chk("urun_pulse", 32'(urun), 32'd1);
      if (u == 2) en = 1'b0;
      cap_frame(32, -1, bits, lrs, fr, lr);
      chk("urun_bits", bits, 32'd0);
    end
    repeat (30) @(negedge clk);
    chk("urun_pulses", 32'(ur_pulses - ur0), 32'd3);
    chk("urun_cnt3", 32'(urun_cnt), 32'd3);

    // Disable mid-frame with a second sample pending.
    fs0 = fs_pulses;
    push(16'h1234, 16'h8001);
    en = 1'b1;
    wait_fs("fs_dis");
    chk("dis_no_urun", 32'(urun), 32'd0);
    push(16'hBEEF, 16'hCAFE);
    cap_frame(32, 5, bits, lrs, fr, lr);
    chk("dis_bits", bits, 32'h1234_8001);
    repeat (30) @(negedge clk);
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (bck || lrck) hi++;
    end
    chk("dis_idle", 32'(hi), 32'd0);
    chk("dis_fs_cnt", 32'(fs_pulses - fs0), 32'd1);
    chk("dis_rdy_held", 32'(rdy), 32'd0);

    // Re-enable: pending sample plays, then reset at bit 20.
    en = 1'b1;
    wait_fs("fs_pend");
    chk("pend_no_urun", 32'(urun), 32'd0);
    cap_frame(20, -1, bits, lrs, fr, lr);
    chk("pend_bits20", bits, 32'h000B_EEFC);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {27'd0, bck, lrck, sdat, fs, urun}, 32'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'd1);
    chk("mid_rst_cnt", 32'(urun_cnt), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push(16'h8421, 16'h7E7E);
    en = 1'b1;
    wait_fs("fs_fresh");
    en = 1'b0;
    chk("fresh_msb", {30'd0, lrck, sdat}, 32'b11);
    cap_frame(32, -1, bits, lrs, fr, lr);
    chk("fresh_bits", bits, 32'h8421_7E7E);
    chk("fresh_first_rise", 32'(fr), 32'd6);

    // Saturation on the 8-cycle-frame instance.
    s_rst = 1'b0;
    s_en  = 1'b1;
    sn = 0;
    w  = 0;
    while (sn < 100 && w < 3000) begin
      @(negedge clk);
      if (s_fs) sn++;
      w++;
    end
    chk("sat_cnt100", 32'(s_cnt), 32'd100);
    w = 0;
    while (sn < 300 && w < 5000) begin
      @(negedge clk);
      if (s_fs) sn++;
      w++;
    end
    chk("sat_frames", 32'(sn), 32'd300);
    chk("sat_cnt255", 32'(s_cnt), 32'd255);
    s_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
